// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_exec_stage_pkg                                           |
// | Description : Shared types, constants and helpers for the ALU execute      |
// |               stage: operation/unary/shift/compare encodings, the          |
// |               configuration word, the stage-1 payload and apply_unary().   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_exec_stage_pkg;

  // Datapath width the stage types are built for; the stage parameters
  // default to these values.
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_BITS = 5;
  localparam int unsigned SHAMT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    UN_ID  = 2'd0,
    UN_NEG = 2'd1,
    UN_NOT = 2'd2
  } e_unary_op;

  typedef enum logic [2:0] {
    SH_SHL = 3'd0,
    SH_ASL = 3'd1,
    SH_SHR = 3'd2,
    SH_ASR = 3'd3,
    SH_ROL = 3'd4,
    SH_ROR = 3'd5
  } e_shift_kind;

  // Amount field is SHAMT_W bits wide, so it is inherently modulo DATA_W.
  typedef struct packed {
    e_shift_kind          kind;
    logic [SHAMT_W-1:0]   amount;
  } s_shift;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_AND = 4'd1,
    OP_OR  = 4'd2,
    OP_XOR = 4'd3,
    OP_SHL = 4'd4,
    OP_ASL = 4'd5,
    OP_SHR = 4'd6,
    OP_ASR = 4'd7,
    OP_ROL = 4'd8,
    OP_ROR = 4'd9
  } e_alu_op;

  typedef enum logic [1:0] {
    CMP_RES_EQ = 2'd0,
    CMP_RES_GT = 2'd1,
    CMP_RES_LT = 2'd2
  } e_cmp_res;

  typedef struct packed {
    e_alu_op   op;
    e_unary_op a_op;
    e_unary_op b_op;
    s_shift    b_shift;
    e_unary_op out_op;
  } s_config;

  // Payload held between stage 1 and the output register.
  typedef struct packed {
    logic [DATA_W-1:0]   a1;
    logic [DATA_W-1:0]   b1;
    e_alu_op             op;
    e_unary_op           out_op;
    logic [TAG_BITS-1:0] tag;
  } s_exec_s1;

  // Unknown encodings collapse to zero rather than passing data through.
  function automatic logic [DATA_W-1:0] apply_unary(e_unary_op op,
                                                    logic [DATA_W-1:0] value);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      UN_ID:   res = value;
      UN_NEG:  res = (~value) + 1'b1;
      UN_NOT:  res = ~value;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_shifter                                                  |
// | Description : Combinational shift/rotate unit shared by the operand-B      |
// |               pre-shift and the shift/rotate core operations.              |
// | Ports       : kind_i   - shift kind (SHL/ASL/SHR/ASR/ROL/ROR)              |
// |               amount_i - shift amount, $clog2(WIDTH) bits                  |
// |               value_i  - operand                                           |
// |               result_o - shifted/rotated value (0 for unknown kinds)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_shifter
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  e_shift_kind                kind_i,
  input  logic [$clog2(WIDTH)-1:0]   amount_i,
  input  logic [WIDTH-1:0]           value_i,
  output logic [WIDTH-1:0]           result_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  // Complementary amount for rotates. With amount 0 this equals WIDTH, and a
  // shift by WIDTH yields zero, so rotate-by-0 returns value_i unchanged.
  logic [SHW:0]     w_inv_amt;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;

  always_comb begin
    w_inv_amt = (SHW+1)'(WIDTH) - {1'b0, amount_i};
    w_rol     = (value_i << amount_i) | (value_i >> w_inv_amt);
    w_ror     = (value_i >> amount_i) | (value_i << w_inv_amt);
  end

  always_comb begin
    result_o = '0;
    case (kind_i)
      SH_SHL, SH_ASL: result_o = value_i << amount_i;
      SH_SHR:         result_o = value_i >> amount_i;
      SH_ASR:         result_o = $unsigned($signed(value_i) >>> amount_i);
      SH_ROL:         result_o = w_rol;
      SH_ROR:         result_o = w_ror;
      default:        result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_exec_stage                                               |
// | Description : Two-stage pipelined ALU execute stage with valid/ready       |
// |               handshakes, full back-pressure and synchronous flush.        |
// |               Stage 1 applies unary ops and the operand-B pre-shift;       |
// |               stage 2 runs the core op, output unary op, compare and flags.|
// | Ports       : clk, rst_n (async active-low), flush (sync kill)             |
// |               in_valid/in_ready, in_a, in_b, in_cfg, in_tag  (upstream)    |
// |               out_valid/out_ready, out_result, out_cmp, out_carry,         |
// |               out_zero, out_tag                              (downstream)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  // Stage-1 payload type is sized from the package; keep these at the
  // package values (retarget by changing DATA_W/TAG_BITS in the package).
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned TAG_W = TAG_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  s_config          in_cfg,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output e_cmp_res         out_cmp,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // ---------------------------------------------------------------- control
  logic s1_valid_q;
  logic out_valid_q;
  logic w_s1_adv;
  logic w_accept;

  assign w_s1_adv = !out_valid_q || out_ready;
  // Depends only on state, flush and out_ready -- never on in_valid.
  assign in_ready = (!s1_valid_q || w_s1_adv) && !flush;
  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------- stage 1
  s_exec_s1         s1_d;
  s_exec_s1         s1_q;
  logic [WIDTH-1:0] w_b_un;
  logic [WIDTH-1:0] w_b1;

  assign w_b_un = apply_unary(in_cfg.b_op, in_b);

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_b_shift (
    .kind_i   (in_cfg.b_shift.kind),
    .amount_i (in_cfg.b_shift.amount),
    .value_i  (w_b_un),
    .result_o (w_b1)
  );

  always_comb begin
    s1_d        = '0;
    s1_d.a1     = apply_unary(in_cfg.a_op, in_a);
    s1_d.b1     = w_b1;
    s1_d.op     = in_cfg.op;
    s1_d.out_op = in_cfg.out_op;
    s1_d.tag    = in_tag;
  end

  // ---------------------------------------------------------------- stage 2
  e_shift_kind      w_core_kind;
  logic [WIDTH-1:0] w_core_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_core;
  logic             w_carry;
  logic [WIDTH-1:0] w_res;
  e_cmp_res         w_cmp;

  // Map core shift/rotate ops onto the shared shifter encoding.
  always_comb begin
    w_core_kind = SH_SHL;
    case (s1_q.op)
      OP_SHL:  w_core_kind = SH_SHL;
      OP_ASL:  w_core_kind = SH_ASL;
      OP_SHR:  w_core_kind = SH_SHR;
      OP_ASR:  w_core_kind = SH_ASR;
      OP_ROL:  w_core_kind = SH_ROL;
      OP_ROR:  w_core_kind = SH_ROR;
      default: w_core_kind = SH_SHL;
    endcase
  end

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_core_shift (
    .kind_i   (w_core_kind),
    .amount_i (s1_q.b1[SHAMT_W-1:0]),
    .value_i  (s1_q.a1),
    .result_o (w_core_sh)
  );

  assign w_sum = {1'b0, s1_q.a1} + {1'b0, s1_q.b1};

  always_comb begin
    w_core  = '0;
    w_carry = 1'b0;
    case (s1_q.op)
      OP_ADD: begin
        w_core  = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_AND:  w_core = s1_q.a1 & s1_q.b1;
      OP_OR:   w_core = s1_q.a1 | s1_q.b1;
      OP_XOR:  w_core = s1_q.a1 ^ s1_q.b1;
      OP_SHL, OP_ASL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: w_core = w_core_sh;
      default: begin
        w_core  = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  assign w_res = apply_unary(s1_q.out_op, w_core);

  // Signed compare of the stage-1 operands, independent of the op.
  always_comb begin
    w_cmp = CMP_RES_EQ;
    if (s1_q.a1 == s1_q.b1) begin
      w_cmp = CMP_RES_EQ;
    end else if ($signed(s1_q.a1) > $signed(s1_q.b1)) begin
      w_cmp = CMP_RES_GT;
    end else begin
      w_cmp = CMP_RES_LT;
    end
  end

  // ---------------------------------------------------------------- registers
  logic [WIDTH-1:0] out_result_q;
  e_cmp_res         out_cmp_q;
  logic             out_carry_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cmp_q    <= CMP_RES_EQ;
      out_carry_q  <= 1'b0;
      out_tag_q    <= '0;
    end else begin
      // Stage 1 occupancy: flush wins, then a new accept, then drain.
      if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (w_accept) begin
        s1_valid_q <= 1'b1;
      end else if (w_s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (w_accept) begin
        s1_q <= s1_d;
      end

      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (w_s1_adv) begin
        out_valid_q <= s1_valid_q;
      end

      // Output data only moves when a real op advances; otherwise it holds.
      if (!flush && w_s1_adv && s1_valid_q) begin
        out_result_q <= w_res;
        out_cmp_q    <= w_cmp;
        out_carry_q  <= w_carry;
        out_tag_q    <= s1_q.tag;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cmp    = out_cmp_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = (out_result_q == '0);
  assign out_tag    = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_exec_stage                                            |
// | Description : Self-checking bench for alu_exec_stage. Expected results are |
// |               queued when an input transfer is seen and compared when the  |
// |               matching output transfer occurs.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  s_config     in_cfg;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  e_cmp_res    out_cmp;
  logic        out_carry;
  logic        out_zero;
  logic [4:0]  out_tag;

  alu_exec_stage #(
    .WIDTH (32),
    .TAG_W (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cfg     (in_cfg),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cmp    (out_cmp),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    e_cmp_res    cmp;
    logic        carry;
    logic        zero;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  bit   stream_done = 1'b0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  function automatic logic [31:0] m_un(e_unary_op op, logic [31:0] v);
    case (op)
      UN_ID:   return v;
      UN_NEG:  return 32'd0 - v;
      UN_NOT:  return ~v;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_shift(e_shift_kind k, int amt, logic [31:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      case (k)
        SH_SHL, SH_ASL: r[i] = (i >= amt) ? v[i-amt] : 1'b0;
        SH_SHR:         r[i] = (i + amt < 32) ? v[i+amt] : 1'b0;
        SH_ASR:         r[i] = (i + amt < 32) ? v[i+amt] : v[31];
        SH_ROL:         r[i] = v[(i - amt + 32) % 32];
        SH_ROR:         r[i] = v[(i + amt) % 32];
        default:        r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic exp_t model(s_config c, logic [31:0] a, logic [31:0] b,
                                 logic [4:0] tag);
    logic [31:0] a1, b1, r;
    logic [32:0] s;
    int          amt;
    exp_t        e;
    a1      = m_un(c.a_op, a);
    b1      = m_shift(c.b_shift.kind, int'(c.b_shift.amount), m_un(c.b_op, b));
    amt     = int'(b1 % 32);
    r       = 32'd0;
    e.carry = 1'b0;
    case (c.op)
      OP_ADD: begin s = {1'b0, a1} + {1'b0, b1}; r = s[31:0]; e.carry = s[32]; end
      OP_AND: r = a1 & b1;
      OP_OR:  r = a1 | b1;
      OP_XOR: r = a1 ^ b1;
      OP_SHL: r = m_shift(SH_SHL, amt, a1);
      OP_ASL: r = m_shift(SH_ASL, amt, a1);
      OP_SHR: r = m_shift(SH_SHR, amt, a1);
      OP_ASR: r = m_shift(SH_ASR, amt, a1);
      OP_ROL: r = m_shift(SH_ROL, amt, a1);
      OP_ROR: r = m_shift(SH_ROR, amt, a1);
      default: r = 32'd0;
    endcase
    e.res  = m_un(c.out_op, r);
    e.zero = (e.res == 32'd0);
    if (a1 == b1)                      e.cmp = CMP_RES_EQ;
    else if ($signed(a1) > $signed(b1)) e.cmp = CMP_RES_GT;
    else                               e.cmp = CMP_RES_LT;
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t mk(logic [31:0] res, e_cmp_res cmp, logic carry,
                              logic [4:0] tag);
    exp_t e;
    e.res = res; e.cmp = cmp; e.carry = carry; e.zero = (res == 32'd0); e.tag = tag;
    return e;
  endfunction

  function automatic s_config mkcfg(e_alu_op op, e_unary_op a_op, e_unary_op b_op,
                                    e_shift_kind k, int amt, e_unary_op out_op);
    s_config c;
    c.op = op; c.a_op = a_op; c.b_op = b_op;
    c.b_shift.kind = k; c.b_shift.amount = 5'(amt); c.out_op = out_op;
    return c;
  endfunction

  // ------------------------------------------------------------ driver
  task automatic set_in(s_config c, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
    in_cfg = c; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
  endtask

  // Presents one op, pushes its expectation at the cycle it is accepted and
  // returns just after the accepting edge.
  task automatic send_exp(s_config c, logic [31:0] a, logic [31:0] b,
                          logic [4:0] tag, exp_t e);
    bit ok;
    ok = 1'b0;
    set_in(c, a, b, tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready 0 expected 1 (tag %0d)", tag);
    end
    if (ok) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(s_config c, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
    send_exp(c, a, b, tag, model(c, a, b, tag));
  endtask

  task automatic wait_drain(string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // ------------------------------------------------------------ output monitor
  bit          hold_prev = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;
  e_cmp_res    prev_cmp;
  logic        prev_carry;

  always @(negedge clk) begin
    if (!rst_n || flush) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) begin
        chk("hold_result", 64'(out_result), 64'(prev_res));
        chk("hold_tag",    64'(out_tag),    64'(prev_tag));
        chk("hold_cmp",    64'(out_cmp),    64'(prev_cmp));
        chk("hold_carry",  64'(out_carry),  64'(prev_carry));
      end
      if (out_valid && out_ready) begin
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_output: observed tag %0d expected none", out_tag);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_out++;
          chk("result", 64'(out_result), 64'(e.res));
          chk("cmp",    64'(out_cmp),    64'(e.cmp));
          chk("carry",  64'(out_carry),  64'(e.carry));
          chk("zero",   64'(out_zero),   64'(e.zero));
          chk("tag",    64'(out_tag),    64'(e.tag));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_res = out_result; prev_tag = out_tag;
      prev_cmp = out_cmp;    prev_carry = out_carry;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ directed steps
  initial begin
    int n0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_tag = '0;
    in_cfg = mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 0, UN_ID);

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_result",    64'(out_result), 64'd0);
    chk("rst_cmp",       64'(out_cmp),    64'(CMP_RES_EQ));
    chk("rst_tag",       64'(out_tag),    64'd0);
    chk("rst_carry",     64'(out_carry),  64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ADD overflow with latency check: output register loads on the edge after accept
    send_exp(mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'hFFFF_FFFF, 32'd1, 5'd1,
             mk(32'h0, CMP_RES_LT, 1'b1, 5'd1));
    chk("lat_not_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    wait_drain("drain_add");

    // NEG on A, NOT on output: a1=FFFFFFFB, r=FFFFFFFE (no wrap past bit 32)
    send_exp(mkcfg(OP_ADD, UN_NEG, UN_ID, SH_SHL, 0, UN_NOT), 32'd5, 32'd3, 5'd2,
             mk(32'h0000_0001, CMP_RES_LT, 1'b0, 5'd2));
    // Shifts and rotates on 0x8000_0001
    send_exp(mkcfg(OP_ROR, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'h8000_0001, 32'd4, 5'd3,
             mk(32'h1800_0000, CMP_RES_LT, 1'b0, 5'd3));
    send_exp(mkcfg(OP_ASR, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'h8000_0001, 32'd4, 5'd4,
             mk(32'hF800_0000, CMP_RES_LT, 1'b0, 5'd4));
    send_exp(mkcfg(OP_SHR, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'h8000_0001, 32'd4, 5'd5,
             mk(32'h0800_0000, CMP_RES_LT, 1'b0, 5'd5));
    send_exp(mkcfg(OP_ROL, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'h8000_0001, 32'd33, 5'd6,
             mk(32'h0000_0003, CMP_RES_LT, 1'b0, 5'd6));
    // Unknown op encoding yields zero result, zero carry
    send_exp(mkcfg(e_alu_op'(4'hF), UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'd7, 32'd7, 5'd7,
             mk(32'h0, CMP_RES_EQ, 1'b0, 5'd7));
    // Operand-B pre-shift: 1 + (1<<4)
    send_exp(mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 4, UN_ID), 32'd1, 32'd1, 5'd8,
             mk(32'h0000_0011, CMP_RES_LT, 1'b0, 5'd8));
    // SUB-like: A + NEG(B) with A greater
    send_exp(mkcfg(OP_ADD, UN_ID, UN_NEG, SH_SHL, 0, UN_ID), 32'd10, 32'd3, 5'd9,
             mk(32'd7, CMP_RES_GT, 1'b1, 5'd9));
    wait_drain("drain_directed");

    // Back-pressure: two ops fill the pipe, the third stalls for 5 cycles
    n0 = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_model(mkcfg(OP_XOR, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'hA5A5_0000, 32'h0F0F_1234, 5'd10);
    send_model(mkcfg(OP_AND, UN_NOT, UN_ID, SH_ROR, 8, UN_ID), 32'h1234_5678, 32'hFFFF_00FF, 5'd11);
    set_in(mkcfg(OP_OR, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'h0000_F000, 32'h0000_000F, 5'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_reassert", 64'(in_ready), 64'd1);
    send_model(mkcfg(OP_OR, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'h0000_F000, 32'h0000_000F, 5'd12);
    send_model(mkcfg(OP_ASL, UN_ID, UN_ID, SH_SHL, 0, UN_NEG), 32'h0000_0003, 32'd2, 5'd13);
    wait_drain("bp_drain");
    chk("bp_count", 64'(n_out - n0), 64'd4);

    // Flush with both stages full and a new op presented
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_model(mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'd100, 32'd200, 5'd14);
    send_model(mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'd300, 32'd400, 5'd15);
    set_in(mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'd1, 32'd1, 5'd16);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_no_accept", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send_model(mkcfg(OP_SUB_SAFE_SHR(), UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'hF000_0000, 32'd8, 5'd17);
    wait_drain("flush_after");

    // Asynchronous reset between edges with the pipe full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_model(mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'd11, 32'd22, 5'd18);
    send_model(mkcfg(OP_ADD, UN_ID, UN_ID, SH_SHL, 0, UN_ID), 32'd33, 32'd44, 5'd19);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    sb.delete();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_stale", 64'(out_valid), 64'd0);
    end
    chk("arst_in_ready_after", 64'(in_ready), 64'd1);
    send_model(mkcfg(OP_XOR, UN_ID, UN_NOT, SH_SHL, 0, UN_ID), 32'h1357_9BDF, 32'h0, 5'd20);
    wait_drain("arst_after");

    // Randomized stream under random back-pressure
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send_model(mkcfg(e_alu_op'($urandom_range(0, 10)),
                           e_unary_op'($urandom_range(0, 3)),
                           e_unary_op'($urandom_range(0, 2)),
                           e_shift_kind'($urandom_range(0, 5)),
                           int'($urandom_range(0, 31)),
                           e_unary_op'($urandom_range(0, 2))),
                     $urandom, $urandom, 5'(i));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Shift-right op used after the flush; kept as a function so the call reads
  // as a plain op selection.
  function automatic e_alu_op OP_SUB_SAFE_SHR();
    return OP_SHR;
  endfunction

endmodule
`default_nettype wire
